lc3_isdu_param: RTL and testbench



---
 rtl/lc3_ctrl_pkg.sv | 63 ++++++
 rtl/mem_wait_timer.sv | 23 ++
 rtl/lc3_isdu_param.sv | 159 +++++++++++++++
 tb/tb_lc3_isdu_param.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_ctrl_pkg.sv
// Shared ISDU types: 5-bit state encoding, opcodes and datapath mux/ALU select codes.
// Pure declarations; no latency or flow control of its own.
package lc3_ctrl_pkg;

    typedef enum logic [4:0] {
        HALTED    = 5'd0,
        FETCH_MAR = 5'd1,
        FETCH_RD  = 5'd2,
        FETCH_IR  = 5'd3,
        DECODE    = 5'd4,
        ALU       = 5'd5,
        BR_CHK    = 5'd6,
        BR_TAKE   = 5'd7,
        JMP       = 5'd8,
        JSR1      = 5'd9,
        JSR2      = 5'd10,
        LEA       = 5'd11,
        ADDR      = 5'd12,
        RD        = 5'd13,
        IND_MAR   = 5'd14,
        MDR_DR    = 5'd15,
        MDR_SR    = 5'd16,
        WR        = 5'd17,
        PAUSE1    = 5'd18,
        PAUSE2    = 5'd19
    } state_t;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_LD    = 4'b0010;
    localparam logic [3:0] OP_ST    = 4'b0011;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_RTI   = 4'b1000;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_LDI   = 4'b1010;
    localparam logic [3:0] OP_STI   = 4'b1011;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;
    localparam logic [3:0] OP_LEA   = 4'b1110;
    localparam logic [3:0] OP_TRAP  = 4'b1111;

    localparam logic [1:0] PC_PLUS1  = 2'b00;
    localparam logic [1:0] PC_ADDER  = 2'b01;
    localparam logic [1:0] PC_BUS    = 2'b10;

    localparam logic [1:0] A2_ZERO   = 2'b00;
    localparam logic [1:0] A2_OFF6   = 2'b01;
    localparam logic [1:0] A2_OFF9   = 2'b10;
    localparam logic [1:0] A2_OFF11  = 2'b11;

    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_NOT   = 2'b10;
    localparam logic [1:0] ALUK_PASSA = 2'b11;

    function automatic logic is_indirect(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_STI);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Read/write wait counter: held at 0 while start is high, counts up otherwise; done when count==limit.
// done is combinational from the count register; no backpressure.
module mem_wait_timer (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       start,
    input  logic [3:0] limit,
    output logic       done
);
    localparam int CW = $clog2(16);

    logic [CW-1:0] count;

    always_ff @(posedge Clk) begin
        if (!Reset_n || start)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    assign done = (count == limit);

endmodule

// File: rtl/lc3_isdu_param.sv
// LC-3 sequencer/decoder with counted SRAM read/write waits; outputs decoded from the state register.
// Reads last MEM_WAIT+1 cycles, writes WR_WAIT cycles; the only stalls are PAUSE waiting on Continue.
module lc3_isdu_param
    import lc3_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 3,
    parameter int unsigned WR_WAIT  = 3,
    parameter bit          PAUSE_EN = 1'b1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_OE,
    output logic       Mem_WE,
    output logic [4:0] State_dbg
);
    state_t     state;
    logic [3:0] op_q;
    logic       ind_q;   // set once the indirect pointer has been moved into MAR
    logic       wait_done;
    logic       in_wait;
    logic [3:0] wait_limit;

    assign in_wait    = (state == FETCH_RD) || (state == RD) || (state == WR);
    assign wait_limit = (state == WR) ? 4'(WR_WAIT - 1) : 4'(MEM_WAIT);

    mem_wait_timer u_timer (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .start   (!in_wait),
        .limit   (wait_limit),
        .done    (wait_done)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= HALTED;
            op_q  <= 4'b0000;
            ind_q <= 1'b0;
        end else begin
            case (state)
                HALTED:    if (Run) state <= FETCH_MAR;
                FETCH_MAR: state <= FETCH_RD;
                FETCH_RD:  if (wait_done) state <= FETCH_IR;
                FETCH_IR:  state <= DECODE;
                DECODE: begin
                    op_q  <= Opcode;
                    ind_q <= 1'b0;
                    case (Opcode)
                        OP_ADD, OP_AND, OP_NOT:         state <= ALU;
                        OP_BR:                          state <= BR_CHK;
                        OP_JMP:                         state <= JMP;
                        OP_JSR:                         state <= JSR1;
                        OP_LEA:                         state <= LEA;
                        OP_LD, OP_LDI, OP_ST, OP_STI,
                        OP_LDR, OP_STR:                 state <= ADDR;
                        OP_PAUSE: state <= PAUSE_EN ? PAUSE1 : FETCH_MAR;
                        default:                        state <= FETCH_MAR;
                    endcase
                end
                BR_CHK:    state <= BEN ? BR_TAKE : FETCH_MAR;
                JSR1:      state <= JSR2;
                ADDR:      state <= (op_q == OP_ST || op_q == OP_STR) ? MDR_SR : RD;
                RD: begin
                    if (wait_done)
                        state <= (is_indirect(op_q) && !ind_q) ? IND_MAR : MDR_DR;
                end
                IND_MAR: begin
                    ind_q <= 1'b1;
                    state <= (op_q == OP_STI) ? MDR_SR : RD;
                end
                MDR_SR:    state <= WR;
                WR:        if (wait_done) state <= FETCH_MAR;
                PAUSE1:    if (Continue) state <= PAUSE2;
                PAUSE2:    if (!Continue) state <= FETCH_MAR;
                default:   state <= FETCH_MAR;
            endcase
        end
    end

    always_comb begin
        LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR  = 1'b0; LD_BEN = 1'b0;
        LD_CC  = 1'b0; LD_REG = 1'b0; LD_PC  = 1'b0; LD_LED = 1'b0;
        GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
        PCMUX  = PC_PLUS1; DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0;
        ADDR1MUX = 1'b0; ADDR2MUX = A2_ZERO; ALUK = ALUK_ADD;
        Mem_OE = 1'b0; Mem_WE = 1'b0;
        case (state)
            FETCH_MAR: begin GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; end
            FETCH_RD, RD: begin Mem_OE = 1'b1; LD_MDR = wait_done; end
            FETCH_IR:  begin GateMDR = 1'b1; LD_IR = 1'b1; end
            DECODE:    LD_BEN = 1'b1;
            ALU: begin
                GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; SR2MUX = IR_5;
                case (op_q)
                    OP_AND:  ALUK = ALUK_AND;
                    OP_NOT:  ALUK = ALUK_NOT;
                    default: ALUK = ALUK_ADD;
                endcase
            end
            BR_TAKE:   begin ADDR2MUX = A2_OFF9; PCMUX = PC_ADDER; LD_PC = 1'b1; end
            JMP:       begin ADDR1MUX = 1'b1; PCMUX = PC_ADDER; LD_PC = 1'b1; end
            JSR1:      begin GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1; end
            JSR2: begin
                ADDR1MUX = !IR_11;
                ADDR2MUX = IR_11 ? A2_OFF11 : A2_ZERO;
                PCMUX    = PC_ADDER;
                LD_PC    = 1'b1;
            end
            LEA: begin
                ADDR2MUX = A2_OFF9; GateMARMUX = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
            end
            ADDR: begin
                GateMARMUX = 1'b1; LD_MAR = 1'b1;
                if (op_q == OP_LDR || op_q == OP_STR) begin
                    ADDR1MUX = 1'b1;
                    ADDR2MUX = A2_OFF6;
                end else begin
                    ADDR2MUX = A2_OFF9;
                end
            end
            IND_MAR:   begin GateMDR = 1'b1; LD_MAR = 1'b1; end
            MDR_DR:    begin GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; end
            MDR_SR: begin
                SR1MUX = 1'b1; ALUK = ALUK_PASSA; GateALU = 1'b1; LD_MDR = 1'b1;
            end
            WR:        Mem_WE = 1'b1;
            PAUSE1, PAUSE2: LD_LED = 1'b1;
            default: ;
        endcase
    end

    assign State_dbg = state;

endmodule

// File: tb/tb_lc3_isdu_param.sv
// Directed checks of the ISDU: per-cycle vector table plus PAUSE, reset and boundary-parameter sequences.
module tb_lc3_isdu_param;
    import lc3_ctrl_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset_n0, Reset_n1;
    logic       Run, Continue, IR_5, IR_11, BEN;
    logic [3:0] Opcode;
    wire  [28:0] o0, o1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    lc3_isdu_param #(.MEM_WAIT(3), .WR_WAIT(2), .PAUSE_EN(1'b1)) dut0 (
        .Clk(Clk), .Reset_n(Reset_n0), .Run(Run), .Continue(Continue),
        .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD_MAR(o0[0]), .LD_MDR(o0[1]), .LD_IR(o0[2]), .LD_BEN(o0[3]),
        .LD_CC(o0[4]), .LD_REG(o0[5]), .LD_PC(o0[6]), .LD_LED(o0[7]),
        .GatePC(o0[8]), .GateMDR(o0[9]), .GateALU(o0[10]), .GateMARMUX(o0[11]),
        .PCMUX(o0[13:12]), .DRMUX(o0[14]), .SR1MUX(o0[15]), .SR2MUX(o0[16]),
        .ADDR1MUX(o0[17]), .ADDR2MUX(o0[19:18]), .ALUK(o0[21:20]),
        .Mem_OE(o0[22]), .Mem_WE(o0[23]), .State_dbg(o0[28:24])
    );

    lc3_isdu_param #(.MEM_WAIT(0), .WR_WAIT(1), .PAUSE_EN(1'b0)) dut1 (
        .Clk(Clk), .Reset_n(Reset_n1), .Run(Run), .Continue(Continue),
        .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD_MAR(o1[0]), .LD_MDR(o1[1]), .LD_IR(o1[2]), .LD_BEN(o1[3]),
        .LD_CC(o1[4]), .LD_REG(o1[5]), .LD_PC(o1[6]), .LD_LED(o1[7]),
        .GatePC(o1[8]), .GateMDR(o1[9]), .GateALU(o1[10]), .GateMARMUX(o1[11]),
        .PCMUX(o1[13:12]), .DRMUX(o1[14]), .SR1MUX(o1[15]), .SR2MUX(o1[16]),
        .ADDR1MUX(o1[17]), .ADDR2MUX(o1[19:18]), .ALUK(o1[21:20]),
        .Mem_OE(o1[22]), .Mem_WE(o1[23]), .State_dbg(o1[28:24])
    );

    // Control-word bit positions, matching the o0/o1 port wiring above
    localparam logic [23:0] LDMAR = 24'h000001, LDMDR = 24'h000002, LDIR  = 24'h000004;
    localparam logic [23:0] LDBEN = 24'h000008, LDCC  = 24'h000010, LDREG = 24'h000020;
    localparam logic [23:0] LDPC  = 24'h000040, LDLED = 24'h000080, GPC   = 24'h000100;
    localparam logic [23:0] GMDR  = 24'h000200, GALU  = 24'h000400, GMMUX = 24'h000800;
    localparam logic [23:0] PCM_ADDR = 24'h001000, DRM = 24'h004000, SR1M = 24'h008000;
    localparam logic [23:0] SR2M  = 24'h010000, A1M   = 24'h020000, A2_6  = 24'h040000;
    localparam logic [23:0] A2_9  = 24'h080000, A2_11 = 24'h0C0000, K_AND = 24'h100000;
    localparam logic [23:0] K_NOT = 24'h200000, K_PA  = 24'h300000, MOE   = 24'h400000;
    localparam logic [23:0] MWE   = 24'h800000;

    localparam logic [23:0] E_FMAR = GPC | LDMAR | LDPC;
    localparam logic [23:0] E_FRD = MOE, E_FRDL = MOE | LDMDR;
    localparam logic [23:0] E_FIR = GMDR | LDIR, E_DEC = LDBEN;
    localparam logic [23:0] E_ADDI = GALU | LDREG | LDCC | SR2M;
    localparam logic [23:0] E_AND = GALU | LDREG | LDCC | K_AND;
    localparam logic [23:0] E_NOT = GALU | LDREG | LDCC | K_NOT;
    localparam logic [23:0] E_BRT = A2_9 | PCM_ADDR | LDPC;
    localparam logic [23:0] E_JMP = A1M | PCM_ADDR | LDPC;
    localparam logic [23:0] E_JSR1 = GPC | DRM | LDREG;
    localparam logic [23:0] E_JSRR = A1M | PCM_ADDR | LDPC;
    localparam logic [23:0] E_JSRL = A2_11 | PCM_ADDR | LDPC;
    localparam logic [23:0] E_LEA = A2_9 | GMMUX | LDREG | LDCC;
    localparam logic [23:0] E_ADDR9 = A2_9 | GMMUX | LDMAR;
    localparam logic [23:0] E_ADDR6 = A1M | A2_6 | GMMUX | LDMAR;
    localparam logic [23:0] E_IND = GMDR | LDMAR, E_MDRDR = GMDR | LDREG | LDCC;
    localparam logic [23:0] E_MDRSR = SR1M | K_PA | GALU | LDMDR;
    localparam logic [23:0] E_WR = MWE, E_PAUSE = LDLED, E_NONE = 24'h0;

    typedef struct {
        logic       run;
        logic [3:0] op;
        logic       ir5;
        logic       ir11;
        logic       ben;
        state_t     st;
        logic [23:0] ctrl;
    } vec_t;

    vec_t tbl[$];

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [28:0] got, input logic [28:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got state=%0d ctrl=%h, expected state=%0d ctrl=%h",
                     nm, got[28:24], got[23:0], exp[28:24], exp[23:0]);
        end
    endtask

    task automatic step_check(input bit inst1, input string nm, input state_t st,
                              input logic [23:0] c);
        step();
        check(nm, inst1 ? o1 : o0, {st, c});
    endtask

    task automatic add(input logic run, input logic [3:0] op, input logic ir5,
                       input logic ir11, input logic ben, input state_t st,
                       input logic [23:0] c);
        vec_t v;
        v.run = run; v.op = op; v.ir5 = ir5; v.ir11 = ir11; v.ben = ben;
        v.st = st; v.ctrl = c;
        tbl.push_back(v);
    endtask

    // From FETCH_MAR: four read cycles (MEM_WAIT=3), IR load, decode
    task automatic add_fetch(input logic run, input logic [3:0] op, input logic ir5,
                             input logic ir11, input logic ben);
        for (int k = 0; k < 3; k++) add(run, op, ir5, ir11, ben, FETCH_RD, E_FRD);
        add(run, op, ir5, ir11, ben, FETCH_RD, E_FRDL);
        add(run, op, ir5, ir11, ben, FETCH_IR, E_FIR);
        add(run, op, ir5, ir11, ben, DECODE, E_DEC);
    endtask

    task automatic add_rd(input logic [3:0] op);
        for (int k = 0; k < 3; k++) add(0, op, 0, 0, 0, RD, E_FRD);
        add(0, op, 0, 0, 0, RD, E_FRDL);
    endtask

    initial begin
        Reset_n0 = 1'b0; Reset_n1 = 1'b0;
        Run = 1'b0; Continue = 1'b0; Opcode = 4'h0;
        IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;

        add(1, 4'h1, 1, 0, 0, FETCH_MAR, E_FMAR);
        add_fetch(0, 4'h1, 1, 0, 0);                      // ADD imm
        add(0, 4'h1, 1, 0, 0, ALU, E_ADDI);
        add(0, 4'h1, 1, 0, 0, FETCH_MAR, E_FMAR);
        add_fetch(1, 4'h5, 0, 0, 0);                      // AND reg, Run held high
        add(1, 4'h5, 0, 0, 0, ALU, E_AND);
        add(1, 4'h5, 0, 0, 0, FETCH_MAR, E_FMAR);
        add_fetch(0, 4'h9, 0, 0, 0);                      // NOT
        add(0, 4'h9, 0, 0, 0, ALU, E_NOT);
        add(0, 4'h9, 0, 0, 0, FETCH_MAR, E_FMAR);
        add_fetch(0, 4'h0, 0, 0, 0);                      // BR not taken
        add(0, 4'h0, 0, 0, 0, BR_CHK, E_NONE);
        add(0, 4'h0, 0, 0, 0, FETCH_MAR, E_FMAR);
        add_fetch(0, 4'h0, 0, 0, 1);                      // BR taken
        add(0, 4'h0, 0, 0, 1, BR_CHK, E_NONE);
        add(0, 4'h0, 0, 0, 1, BR_TAKE, E_BRT);
        add(0, 4'h0, 0, 0, 1, FETCH_MAR, E_FMAR);
        add_fetch(0, 4'h4, 0, 0, 0);                      // JSRR
        add(0, 4'h4, 0, 0, 0, JSR1, E_JSR1);
        add(0, 4'h4, 0, 0, 0, JSR2, E_JSRR);
        add(0, 4'h4, 0, 0, 0, FETCH_MAR, E_FMAR);
        add_fetch(0, 4'h4, 0, 1, 0);                      // JSR
        add(0, 4'h4, 0, 1, 0, JSR1, E_JSR1);
        add(0, 4'h4, 0, 1, 0, JSR2, E_JSRL);
        add(0, 4'h4, 0, 1, 0, FETCH_MAR, E_FMAR);
        add_fetch(0, 4'hC, 0, 0, 0);                      // JMP
        add(0, 4'hC, 0, 0, 0, JMP, E_JMP);
        add(0, 4'hC, 0, 0, 0, FETCH_MAR, E_FMAR);
        add_fetch(0, 4'hE, 0, 0, 0);                      // LEA
        add(0, 4'hE, 0, 0, 0, LEA, E_LEA);
        add(0, 4'hE, 0, 0, 0, FETCH_MAR, E_FMAR);
        add_fetch(0, 4'hA, 0, 0, 0);                      // LDI: two reads around IND_MAR
        add(0, 4'hA, 0, 0, 0, ADDR, E_ADDR9);
        add_rd(4'hA);
        add(0, 4'hA, 0, 0, 0, IND_MAR, E_IND);
        add_rd(4'hA);
        add(0, 4'hA, 0, 0, 0, MDR_DR, E_MDRDR);
        add(0, 4'hA, 0, 0, 0, FETCH_MAR, E_FMAR);
        add_fetch(0, 4'hB, 0, 0, 0);                      // STI: read, IND_MAR, 2-cycle write
        add(0, 4'hB, 0, 0, 0, ADDR, E_ADDR9);
        add_rd(4'hB);
        add(0, 4'hB, 0, 0, 0, IND_MAR, E_IND);
        add(0, 4'hB, 0, 0, 0, MDR_SR, E_MDRSR);
        add(0, 4'hB, 0, 0, 0, WR, E_WR);
        add(0, 4'hB, 0, 0, 0, WR, E_WR);
        add(0, 4'hB, 0, 0, 0, FETCH_MAR, E_FMAR);
        add_fetch(0, 4'h7, 0, 0, 0);                      // STR
        add(0, 4'h7, 0, 0, 0, ADDR, E_ADDR6);
        add(0, 4'h7, 0, 0, 0, MDR_SR, E_MDRSR);
        add(0, 4'h7, 0, 0, 0, WR, E_WR);
        add(0, 4'h7, 0, 0, 0, WR, E_WR);
        add(0, 4'h7, 0, 0, 0, FETCH_MAR, E_FMAR);
        add_fetch(0, 4'hF, 0, 0, 0);                      // TRAP is illegal here
        add(0, 4'hF, 0, 0, 0, FETCH_MAR, E_FMAR);

        step(); step();
        check("reset_halted", o0, {HALTED, E_NONE});
        Reset_n0 = 1'b1;
        step_check(0, "idle_no_run", HALTED, E_NONE);

        for (int i = 0; i < tbl.size(); i++) begin
            Run = tbl[i].run; Opcode = tbl[i].op; IR_5 = tbl[i].ir5;
            IR_11 = tbl[i].ir11; BEN = tbl[i].ben;
            step();
            check($sformatf("vec%0d", i), o0, {tbl[i].st, tbl[i].ctrl});
        end
        Run = 1'b0; IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;

        // PAUSE: hold in PAUSE1 until Continue rises, PAUSE2 until it falls
        Opcode = 4'hD; Continue = 1'b0;
        repeat (5) step();
        step_check(0, "pause_decode", DECODE, E_DEC);
        for (int k = 0; k < 10; k++) step_check(0, "pause1_hold", PAUSE1, E_PAUSE);
        Continue = 1'b1;
        step_check(0, "pause2_enter", PAUSE2, E_PAUSE);
        step_check(0, "pause2_hold", PAUSE2, E_PAUSE);
        Continue = 1'b0;
        step_check(0, "pause_exit", FETCH_MAR, E_FMAR);

        // Reset in the middle of a write
        Opcode = 4'h7;
        repeat (7) step();
        step_check(0, "str_mdr_sr", MDR_SR, E_MDRSR);
        step_check(0, "str_wr", WR, E_WR);
        Reset_n0 = 1'b0;
        step_check(0, "reset_mid_wr", HALTED, E_NONE);
        Reset_n0 = 1'b1;
        step_check(0, "stay_halted", HALTED, E_NONE);
        Reset_n0 = 1'b0;

        // MEM_WAIT=0, WR_WAIT=1, PAUSE_EN=0
        step_check(1, "i1_reset", HALTED, E_NONE);
        Reset_n1 = 1'b1; Run = 1'b1;
        step_check(1, "i1_run", FETCH_MAR, E_FMAR);
        Run = 1'b0; Opcode = 4'hD;
        step_check(1, "i1_rd1", FETCH_RD, E_FRDL);
        step_check(1, "i1_ir", FETCH_IR, E_FIR);
        step_check(1, "i1_dec", DECODE, E_DEC);
        step_check(1, "i1_1101_illegal", FETCH_MAR, E_FMAR);
        Opcode = 4'h3;
        step_check(1, "i1_st_rd", FETCH_RD, E_FRDL);
        step(); step();
        step_check(1, "i1_st_addr", ADDR, E_ADDR9);
        step_check(1, "i1_st_mdr", MDR_SR, E_MDRSR);
        step_check(1, "i1_st_wr1", WR, E_WR);
        step_check(1, "i1_st_done", FETCH_MAR, E_FMAR);
        Opcode = 4'h2;
        repeat (3) step();
        step_check(1, "i1_ld_addr", ADDR, E_ADDR9);
        step_check(1, "i1_ld_rd1", RD, E_FRDL);
        step_check(1, "i1_ld_mdrdr", MDR_DR, E_MDRDR);
        step_check(1, "i1_ld_done", FETCH_MAR, E_FMAR);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
